// File: rtl/zone_climate_ctrl_if.sv
// -----------------------------------------------------------------------------
// zone_climate_ctrl_if
// Bus between the smart-home top level and the multi-zone climate controller.
//   master : drives mode, zone_en, temperature, fault_clr;
//            observes heating, cooling, fault, active_count.
//   slave  : the controller side (mirror of master).
// -----------------------------------------------------------------------------
interface zone_climate_ctrl_if #(
   parameter int ZONES  = 4,
   parameter int TEMP_W = 5
);
   localparam int CNT_W = $clog2(ZONES + 1);

   logic [1:0]              mode;
   logic [ZONES-1:0]        zone_en;
   logic [ZONES*TEMP_W-1:0] temperature;
   logic [ZONES-1:0]        fault_clr;
   logic [ZONES-1:0]        heating;
   logic [ZONES-1:0]        cooling;
   logic [ZONES-1:0]        fault;
   logic [CNT_W-1:0]        active_count;

   modport master (
      output mode, zone_en, temperature, fault_clr,
      input  heating, cooling, fault, active_count
   );

   modport slave (
      input  mode, zone_en, temperature, fault_clr,
      output heating, cooling, fault, active_count
   );
endinterface

// File: rtl/zone_climate_ctrl.sv
// -----------------------------------------------------------------------------
// zone_climate_ctrl
// One IDLE/HEAT/COOL hysteresis machine per zone with a global mode, per-zone
// enables, a minimum-dwell lockout against short-cycling, sticky sensor-fault
// flags and a registered count of active zones.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : zone_climate_ctrl_if.slave (mode, zone_en, temperature, fault_clr in;
//          heating, cooling, fault, active_count out, all registered)
// -----------------------------------------------------------------------------
module zone_climate_ctrl #(
   parameter int ZONES     = 4,
   parameter int TEMP_W    = 5,
   parameter int HEAT_ON   = 18,
   parameter int HEAT_OFF  = 20,
   parameter int COOL_ON   = 24,
   parameter int COOL_OFF  = 22,
   parameter int MIN_DWELL = 16
) (
   input logic                 clk,
   input logic                 rst,
   zone_climate_ctrl_if.slave  bus
);
   localparam int CNT_W = $clog2(ZONES + 1);
   localparam int DW_W  = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;

   localparam logic [DW_W-1:0]   DWELL_LOAD = DW_W'(MIN_DWELL - 1);
   localparam logic [TEMP_W-1:0] T_FAULT    = {TEMP_W{1'b1}};
   localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
   localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
   localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
   localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAT = 2'd1,
      ST_COOL = 2'd2
   } state_e;

   state_e            state_q [ZONES];
   state_e            state_d [ZONES];
   logic [DW_W-1:0]   dwell_q [ZONES];
   logic [DW_W-1:0]   dwell_d [ZONES];
   logic [TEMP_W-1:0] temp_s  [ZONES];
   logic [ZONES-1:0]  force_s;
   logic [ZONES-1:0]  fault_q, fault_d;
   logic [ZONES-1:0]  heating_q, heating_d;
   logic [ZONES-1:0]  cooling_q, cooling_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic heat_allowed_s;
   logic cool_allowed_s;

   // Unpack per-zone temperatures and decode which modes permit each direction.
   always_comb begin
      for (int i = 0; i < ZONES; i++) begin
         temp_s[i] = bus.temperature[i*TEMP_W +: TEMP_W];
      end
      heat_allowed_s = (bus.mode == 2'b00) || (bus.mode == 2'b01);
      cool_allowed_s = (bus.mode == 2'b00) || (bus.mode == 2'b10);
   end

   // Per-zone next state, dwell counter, sticky fault and output decode.
   always_comb begin
      force_s   = '0;
      fault_d   = fault_q;
      heating_d = '0;
      cooling_d = '0;
      for (int i = 0; i < ZONES; i++) begin
         state_d[i] = state_q[i];
         dwell_d[i] = dwell_q[i];
         // The force uses the registered fault, so a new fault acts one edge later.
         force_s[i] = !bus.zone_en[i] || (bus.mode == 2'b11) || fault_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (!force_s[i] && (dwell_q[i] == '0)) begin
                  if (heat_allowed_s && (temp_s[i] <= T_HEAT_ON)) begin
                     state_d[i] = ST_HEAT;
                  end else if (cool_allowed_s && (temp_s[i] >= T_COOL_ON)) begin
                     state_d[i] = ST_COOL;
                  end else begin
                     state_d[i] = ST_IDLE;
                  end
               end else begin
                  state_d[i] = ST_IDLE;
               end
            end
            ST_HEAT: begin
               if (force_s[i] || (bus.mode == 2'b10)) begin
                  state_d[i] = ST_IDLE;
               end else if ((dwell_q[i] == '0) && (temp_s[i] >= T_HEAT_OFF)) begin
                  state_d[i] = ST_IDLE;
               end else begin
                  state_d[i] = ST_HEAT;
               end
            end
            ST_COOL: begin
               if (force_s[i] || (bus.mode == 2'b01)) begin
                  state_d[i] = ST_IDLE;
               end else if ((dwell_q[i] == '0) && (temp_s[i] <= T_COOL_OFF)) begin
                  state_d[i] = ST_IDLE;
               end else begin
                  state_d[i] = ST_COOL;
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
            end
         endcase

         // Every state change (forced or not) restarts the dwell window.
         if (state_d[i] != state_q[i]) begin
            dwell_d[i] = DWELL_LOAD;
         end else if (dwell_q[i] != '0) begin
            dwell_d[i] = dwell_q[i] - DW_W'(1);
         end else begin
            dwell_d[i] = dwell_q[i];
         end

         // Set has priority over clear.
         if (temp_s[i] == T_FAULT) begin
            fault_d[i] = 1'b1;
         end else if (bus.fault_clr[i]) begin
            fault_d[i] = 1'b0;
         end else begin
            fault_d[i] = fault_q[i];
         end

         heating_d[i] = (state_d[i] == ST_HEAT);
         cooling_d[i] = (state_d[i] == ST_COOL);
      end
   end

   // Count active zones from the same next-state values that feed the outputs.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < ZONES; i++) begin
         count_d = count_d + CNT_W'(heating_d[i] | cooling_d[i]);
      end
   end

   // State, dwell, fault and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ZONES; i++) begin
            state_q[i] <= ST_IDLE;
            dwell_q[i] <= '0;
         end
         fault_q   <= '0;
         heating_q <= '0;
         cooling_q <= '0;
         count_q   <= '0;
      end else begin
         for (int i = 0; i < ZONES; i++) begin
            state_q[i] <= state_d[i];
            dwell_q[i] <= dwell_d[i];
         end
         fault_q   <= fault_d;
         heating_q <= heating_d;
         cooling_q <= cooling_d;
         count_q   <= count_d;
      end
   end

   assign bus.heating      = heating_q;
   assign bus.cooling      = cooling_q;
   assign bus.fault        = fault_q;
   assign bus.active_count = count_q;

endmodule
